// File: rtl/unidade_controle_multiciclo.sv
// Multicycle RISC-V control FSM: fetch/decode/execute/memory/writeback with a memory
// ready handshake, wait timeout and halt. Define CONTADOR_CICLOS_EN to build the cycle counter.
module unidade_controle_multiciclo #(
  parameter int CONT_W      = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        opcode,
  input  logic              mem_ready,
  output logic [2:0]        estado,
  output logic              pcwrite,
  output logic              pcwritecond,
  output logic              irwrite,
  output logic              memread,
  output logic              memwrite,
  output logic              iord,
  output logic              regiwrite,
  output logic              memtoreg,
  output logic              alusrc,
  output logic [1:0]        aluop,
  output logic              halted,
  output logic              erro,
  output logic [CONT_W-1:0] instr_count,
  output logic [CONT_W-1:0] ciclos
);

  // ESCRITA is fixed at 010 because the register bank decodes that code directly.
  typedef enum logic [2:0] {
    BUSCA      = 3'b000,
    DECODIFICA = 3'b001,
    ESCRITA    = 3'b010,
    EXECUTA    = 3'b011,
    MEMORIA    = 3'b100,
    HALT       = 3'b111
  } estado_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_FIM = 7'b0000000;

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  estado_t             estado_q;
  logic [6:0]          opcode_q;
  logic                erro_q;
  logic [WAIT_W-1:0]   espera_q;
  logic [WAIT_W-1:0]   espera_nxt;
  logic [CONT_W-1:0]   instr_q;
  logic                estouro;

  assign espera_nxt = espera_q + WAIT_W'(1);
  // A completing handshake always wins over the timeout on the same cycle.
  assign estouro    = (MEM_TIMEOUT > 0) && !mem_ready && (espera_nxt == WAIT_W'(MEM_TIMEOUT));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= BUSCA;
      opcode_q <= '0;
      erro_q   <= 1'b0;
      espera_q <= '0;
      instr_q  <= '0;
    end else begin
      case (estado_q)
        BUSCA: begin
          if (mem_ready) begin
            estado_q <= DECODIFICA;
            espera_q <= '0;
          end else if (estouro) begin
            estado_q <= HALT;
            erro_q   <= 1'b1;
            espera_q <= '0;
          end else begin
            espera_q <= espera_nxt;
          end
        end
        DECODIFICA: begin
          opcode_q <= opcode;
          case (opcode)
            OP_FIM:                           estado_q <= HALT;
            OP_R, OP_I, OP_LW, OP_SW, OP_BEQ: estado_q <= EXECUTA;
            default: begin
              estado_q <= HALT;
              erro_q   <= 1'b1;
            end
          endcase
        end
        EXECUTA: begin
          case (opcode_q)
            OP_R, OP_I:   estado_q <= ESCRITA;
            OP_LW, OP_SW: estado_q <= MEMORIA;
            OP_BEQ: begin
              estado_q <= BUSCA;
              instr_q  <= instr_q + CONT_W'(1);
            end
            default: begin
              estado_q <= HALT;
              erro_q   <= 1'b1;
            end
          endcase
        end
        MEMORIA: begin
          if (mem_ready) begin
            espera_q <= '0;
            if (opcode_q == OP_LW) begin
              estado_q <= ESCRITA;
            end else begin
              estado_q <= BUSCA;
              instr_q  <= instr_q + CONT_W'(1);
            end
          end else if (estouro) begin
            estado_q <= HALT;
            erro_q   <= 1'b1;
            espera_q <= '0;
          end else begin
            espera_q <= espera_nxt;
          end
        end
        ESCRITA: begin
          estado_q <= BUSCA;
          instr_q  <= instr_q + CONT_W'(1);
        end
        HALT: estado_q <= HALT;
        default: begin
          estado_q <= HALT;
          erro_q   <= 1'b1;
        end
      endcase
    end
  end

  // Strobes are forced low while reset is held, even though BUSCA is the reset state.
  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    irwrite     = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    iord        = 1'b0;
    regiwrite   = 1'b0;
    memtoreg    = 1'b0;
    alusrc      = 1'b0;
    aluop       = 2'b00;
    if (rst_n) begin
      case (estado_q)
        BUSCA: begin
          memread = 1'b1;
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        EXECUTA: begin
          case (opcode_q)
            OP_R: aluop = 2'b10;
            OP_I: begin
              alusrc = 1'b1;
              aluop  = 2'b11;
            end
            OP_LW, OP_SW: alusrc = 1'b1;
            OP_BEQ: begin
              aluop       = 2'b01;
              pcwritecond = 1'b1;
            end
            default: aluop = 2'b00;
          endcase
        end
        MEMORIA: begin
          iord     = 1'b1;
          memread  = (opcode_q == OP_LW);
          memwrite = (opcode_q == OP_SW);
        end
        ESCRITA: begin
          regiwrite = 1'b1;
          memtoreg  = (opcode_q == OP_LW);
        end
        default: regiwrite = 1'b0;
      endcase
    end
  end

  assign estado      = estado_q;
  assign halted      = (estado_q == HALT);
  assign erro        = erro_q;
  assign instr_count = instr_q;

`ifdef CONTADOR_CICLOS_EN
  logic [CONT_W-1:0] ciclos_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ciclos_q <= '0;
    end else if (estado_q != HALT) begin
      ciclos_q <= ciclos_q + CONT_W'(1);
    end
  end

  assign ciclos = ciclos_q;
`else
  assign ciclos = '0;
`endif

endmodule
